// File: rtl/nco_phase_accumulator.sv
// nco_phase_accumulator
//   Phase generator ahead of nco_scaler_summer. Advances a phase accumulator by a
//   double-buffered frequency control word once per sample tick while a note is
//   running, and offers each phase through a single-entry valid/ready register.
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   fcw           frequency control word (phase increment per sample)
//   fcw_valid     load fcw into the pending register this cycle
//   note_start    pulse: begin note (clear phase, enter RUN)
//   note_release  pulse: end note (drain output, return to IDLE)
//   phase_out     phase word to the summer (upper 8 bits index its LUTs)
//   phase_valid   phase_out holds an unconsumed sample
//   phase_ready   downstream accepts phase_out when phase_valid & phase_ready
//   active        high in RUN or RELEASE
//   overrun       sticky: a tick found the output register still full
`timescale 1ns/1ps

module nco_phase_accumulator #(
  parameter int unsigned CYCLES_PER_SAMPLE = 1024,
  parameter int unsigned ACC_WIDTH         = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ACC_WIDTH-1:0] fcw,
  input  logic                 fcw_valid,
  input  logic                 note_start,
  input  logic                 note_release,
  output logic [ACC_WIDTH-1:0] phase_out,
  output logic                 phase_valid,
  input  logic                 phase_ready,
  output logic                 active,
  output logic                 overrun
);

  localparam int unsigned CNT_W = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CYCLES_PER_SAMPLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [ACC_WIDTH-1:0] acc, acc_next;
  logic [ACC_WIDTH-1:0] fcw_pending, fcw_pending_next;
  logic [CNT_W-1:0]     tick_cnt, tick_cnt_next;
  logic [ACC_WIDTH-1:0] phase_out_next;
  logic                 phase_valid_next;
  logic                 overrun_next;

  logic tick;
  logic slot_free;
  logic out_taken;

  assign tick      = (tick_cnt == TICK_LAST);
  assign out_taken = phase_valid & phase_ready;
  // Output register can accept a new sample if empty or being drained this cycle.
  assign slot_free = ~phase_valid | phase_ready;

  // Next-state and datapath update.
  always_comb begin
    state_next       = state;
    acc_next         = acc;
    fcw_pending_next = fcw_valid ? fcw : fcw_pending;
    tick_cnt_next    = tick ? '0 : tick_cnt + CNT_W'(1);
    phase_out_next   = phase_out;
    phase_valid_next = phase_valid & ~phase_ready;
    overrun_next     = overrun;

    unique case (state)
      ST_IDLE: begin
        if (note_start) begin
          state_next    = ST_RUN;
          acc_next      = '0;
          tick_cnt_next = '0;
          overrun_next  = 1'b0;
        end
      end

      ST_RUN: begin
        if (note_start) begin
          // Restart: phase realigns to zero, any pending output is still offered.
          acc_next      = '0;
          tick_cnt_next = '0;
          overrun_next  = 1'b0;
        end else if (note_release) begin
          // Drain only if a sample will still be waiting after this cycle.
          state_next = (phase_valid & ~phase_ready) ? ST_RELEASE : ST_IDLE;
        end else if (tick) begin
          acc_next = acc + fcw_pending;
          if (slot_free) begin
            phase_out_next   = acc;
            phase_valid_next = 1'b1;
          end else begin
            overrun_next = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        if (note_start) begin
          state_next    = ST_RUN;
          acc_next      = '0;
          tick_cnt_next = '0;
          overrun_next  = 1'b0;
        end else if (out_taken) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc         <= '0;
      fcw_pending <= '0;
      tick_cnt    <= '0;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      active      <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      acc         <= acc_next;
      fcw_pending <= fcw_pending_next;
      tick_cnt    <= tick_cnt_next;
      phase_out   <= phase_out_next;
      phase_valid <= phase_valid_next;
      active      <= (state_next != ST_IDLE);
      overrun     <= overrun_next;
    end
  end

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// tb_nco_phase_accumulator
//   Directed bench for nco_phase_accumulator with four clocks per sample.
`timescale 1ns/1ps

module tb_nco_phase_accumulator;

  localparam int unsigned CPS = 4;
  localparam int unsigned AW  = 24;

  logic          clk;
  logic          rst;
  logic [AW-1:0] fcw;
  logic          fcw_valid;
  logic          note_start;
  logic          note_release;
  logic [AW-1:0] phase_out;
  logic          phase_valid;
  logic          phase_ready;
  logic          active;
  logic          overrun;

  int total;
  int bad;

  nco_phase_accumulator #(
    .CYCLES_PER_SAMPLE(CPS),
    .ACC_WIDTH        (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fcw         (fcw),
    .fcw_valid   (fcw_valid),
    .note_start  (note_start),
    .note_release(note_release),
    .phase_out   (phase_out),
    .phase_valid (phase_valid),
    .phase_ready (phase_ready),
    .active      (active),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_fcw(input logic [AW-1:0] w);
    fcw       = w;
    fcw_valid = 1'b1;
    step(1);
    fcw_valid = 1'b0;
  endtask

  task automatic start_note();
    note_start = 1'b1;
    step(1);
    note_start = 1'b0;
  endtask

  // Bounded wait for the next sample; an expired bound shows up as a failed check.
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (phase_valid !== 1'b1 && n < 2 * CPS) begin
      step(1);
      n++;
    end
    check({tag, "_valid"}, 32'(phase_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    fcw          = '0;
    fcw_valid    = 1'b0;
    note_start   = 1'b0;
    note_release = 1'b0;
    phase_ready  = 1'b1;
    step(2);
    check("rst_phase_out", 32'(phase_out), 32'h0);
    check("rst_valid",     32'(phase_valid), 32'h0);
    check("rst_active",    32'(active), 32'h0);
    check("rst_overrun",   32'(overrun), 32'h0);
    rst = 1'b0;
    step(1);

    // 1: ramp 0x010000 per sample, exact first-sample latency, full wrap
    load_fcw(24'h010000);
    start_note();
    check("t1_active", 32'(active), 32'd1);
    step(3);
    check("t1_early_valid", 32'(phase_valid), 32'd0);
    step(1);
    check("t1_first_valid", 32'(phase_valid), 32'd1);
    check("t1_first_phase", 32'(phase_out), 32'h000000);
    for (int k = 1; k <= 256; k++) begin
      step(1);
      wait_valid("t1");
      check("t1_phase", 32'(phase_out), 32'(24'(k * 32'h10000)));
    end
    step(1);

    // 2: half-turn increment, carry dropped
    load_fcw(24'h800000);
    start_note();
    step(4);
    check("t2_s0", 32'(phase_out), 32'h000000);
    step(1);
    wait_valid("t2");
    check("t2_s1", 32'(phase_out), 32'h800000);
    step(1);
    wait_valid("t2");
    check("t2_s2", 32'(phase_out), 32'h000000);
    step(1);

    // 3: stalled consumer across three ticks
    load_fcw(24'h010000);
    phase_ready = 1'b0;
    start_note();
    step(4);
    check("t3_s0", 32'(phase_out), 32'h000000);
    check("t3_no_overrun", 32'(overrun), 32'd0);
    step(12);
    check("t3_held_phase", 32'(phase_out), 32'h000000);
    check("t3_held_valid", 32'(phase_valid), 32'd1);
    check("t3_overrun", 32'(overrun), 32'd1);
    phase_ready = 1'b1;
    step(1);
    check("t3_drained", 32'(phase_valid), 32'd0);
    step(2);
    check("t3_gap", 32'(phase_valid), 32'd0);
    step(1);
    check("t3_next_valid", 32'(phase_valid), 32'd1);
    check("t3_next_phase", 32'(phase_out), 32'h040000);
    check("t3_overrun_sticky", 32'(overrun), 32'd1);
    step(1);

    // 4: FCW change mid-sample and on the tick cycle
    start_note();
    check("t4_overrun_cleared", 32'(overrun), 32'd0);
    step(4);
    check("t4_s0", 32'(phase_out), 32'h000000);
    step(1);
    load_fcw(24'h020000);
    step(2);
    check("t4_s1", 32'(phase_out), 32'h010000);
    step(4);
    check("t4_s2", 32'(phase_out), 32'h030000);
    step(3);
    fcw       = 24'h100000;
    fcw_valid = 1'b1;
    step(1);
    fcw_valid = 1'b0;
    check("t4_s3", 32'(phase_out), 32'h050000);
    step(4);
    check("t4_s4", 32'(phase_out), 32'h070000);
    step(4);
    check("t4_s5", 32'(phase_out), 32'h170000);
    step(1);

    // 5: release while a sample is still pending
    load_fcw(24'h010000);
    phase_ready = 1'b0;
    start_note();
    step(4);
    check("t5_pending", 32'(phase_valid), 32'd1);
    note_release = 1'b1;
    step(1);
    note_release = 1'b0;
    check("t5_release_active", 32'(active), 32'd1);
    step(8);
    check("t5_frozen_phase", 32'(phase_out), 32'h000000);
    check("t5_frozen_valid", 32'(phase_valid), 32'd1);
    check("t5_no_overrun", 32'(overrun), 32'd0);
    phase_ready = 1'b1;
    step(1);
    check("t5_idle_active", 32'(active), 32'd0);
    check("t5_idle_valid", 32'(phase_valid), 32'd0);
    step(8);
    check("t5_idle_quiet", 32'(phase_valid), 32'd0);

    // 6: asynchronous reset mid-note, then simultaneous start/release
    start_note();
    step(8);
    phase_ready = 1'b0;
    step(4);
    check("t6_pre_phase", 32'(phase_out), 32'h010000);
    check("t6_pre_overrun", 32'(overrun), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_phase", 32'(phase_out), 32'h0);
    check("t6_rst_valid", 32'(phase_valid), 32'h0);
    check("t6_rst_active", 32'(active), 32'h0);
    check("t6_rst_overrun", 32'(overrun), 32'h0);
    step(1);
    rst = 1'b0;
    phase_ready = 1'b1;
    step(1);
    note_start   = 1'b1;
    note_release = 1'b1;
    step(1);
    note_start   = 1'b0;
    note_release = 1'b0;
    check("t6_both_active", 32'(active), 32'd1);
    // Reset cleared the pending FCW, so the phase stays at zero.
    step(8);
    check("t6_zero_fcw_valid", 32'(phase_valid), 32'd1);
    check("t6_zero_fcw_phase", 32'(phase_out), 32'h000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
